// File: rtl/ins_fetch_mem_pkg.sv
// Shared types and defaults for the instruction fetch memory.
package ins_fetch_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_DW       = 16;
  localparam int unsigned DEF_WAIT_CYC = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned FETCH_AW     = 16;

endpackage

// File: rtl/ins_fetch_mem_ram_array.sv
// Single write port, synchronous-read instruction array; a read that hits the
// word being written in the same edge returns the new data.
module ins_ram_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto plain RAM and keeps the program image across a CPU reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_fetch_mem.sv
// Instruction memory with edge-triggered fetch request, fixed wait latency,
// one-cycle ack, and a host load port that is refused while a fetch is in flight.
module ins_fetch_mem
  import ins_fetch_mem_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [FETCH_AW-1:0] addr,
  output logic [DW-1:0]       ins,
  output logic                ack,
  output logic                busy,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [DW-1:0]       ld_data,
  output logic                ld_rej
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_lat_q, a_lat_d;
  logic          req_q;
  logic          ld_rej_q;
  logic          ins_vld_q;
  logic          start;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  // Upper fetch-address bits are architecturally ignored (fetches wrap).
  generate
    if (AW < FETCH_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[FETCH_AW-1:AW];
    end
  endgenerate

  assign start = (state_q == S_IDLE) && req && !req_q;

  // NOTE: every variable gets its default before the case, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_lat_d = a_lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_lat_d = addr[AW-1:0];
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The word is read on the edge that enters ACK, so a load accepted at the
  // start edge is always visible to the fetch it coincides with.
  assign ram_we    = ld_en && (state_q == S_IDLE);
  assign ram_re    = (state_d == S_ACK);
  assign ram_raddr = (state_q == S_IDLE) ? addr[AW-1:0] : a_lat_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_lat_q   <= '0;
      req_q     <= 1'b0;
      ld_rej_q  <= 1'b0;
      ins_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lat_q   <= a_lat_d;
      req_q     <= req;
      ld_rej_q  <= ld_en && (state_q != S_IDLE);
      ins_vld_q <= ins_vld_q || (state_d == S_ACK);
    end
  end

  ins_ram_array #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // The array has no reset, so a validity flag forces ins to zero until the
  // first fetch completes after reset.
  assign ins    = ins_vld_q ? ram_rdata : '0;
  assign ack    = (state_q == S_ACK);
  assign busy   = (state_q != S_IDLE);
  assign ld_rej = ld_rej_q;

endmodule

// File: tb/tb_ins_fetch_mem.sv
// Directed bench for ins_fetch_mem with AW=8, WAIT_CYC=2.
module tb_ins_fetch_mem;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [15:0]   addr;
  logic [DW-1:0] ins;
  logic          ack;
  logic          busy;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_rej;

  int n_vec = 0;
  int n_err = 0;

  ins_fetch_mem #(
    .AW       (AW),
    .DW       (DW),
    .WAIT_CYC (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr    (addr),
    .ins     (ins),
    .ack     (ack),
    .busy    (busy),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ld_rej  (ld_rej)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en = 1'b0;
    check("load_no_rej", 32'(ld_rej), 32'd0);
  endtask

  // Steps 10 edges from the start edge; lat is the cycle index of the first ack.
  task automatic wait_ack(output int lat, output int n_ack);
    lat   = 0;
    n_ack = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (ack === 1'b1) begin
        n_ack++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic do_fetch(input logic [15:0] a, input logic [DW-1:0] exp, input string tag);
    int lat;
    int na;
    req = 1'b0;
    step();
    addr = a;
    req  = 1'b1;
    wait_ack(lat, na);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_nack"}, 32'(na), 32'd1);
    check({tag, "_ins"}, 32'(ins), 32'(exp));
    req = 1'b0;
  endtask

  initial begin
    int lat;
    int na;
    rst     = 1'b1;
    req     = 1'b0;
    addr    = '0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    step();
    check("rst_ins", 32'(ins), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ldrej", 32'(ld_rej), 32'd0);
    rst = 1'b0;
    step();

    load(8'd3, 16'hA5C3);
    load(8'd5, 16'h5555);
    load(8'd7, 16'h7777);
    load(8'd9, 16'h0999);

    // 1: cycle-accurate latency and busy window
    addr = 16'd3;
    req  = 1'b1;
    step();
    check("t1_n1_busy", 32'(busy), 32'd1);
    check("t1_n1_ack", 32'(ack), 32'd0);
    step();
    check("t1_n2_busy", 32'(busy), 32'd1);
    check("t1_n2_ack", 32'(ack), 32'd0);
    step();
    check("t1_n3_busy", 32'(busy), 32'd1);
    check("t1_n3_ack", 32'(ack), 32'd1);
    check("t1_n3_ins", 32'(ins), 32'hA5C3);
    step();
    check("t1_n4_busy", 32'(busy), 32'd0);
    check("t1_n4_ack", 32'(ack), 32'd0);
    check("t1_n4_ins_held", 32'(ins), 32'hA5C3);

    // 2: held level does not retrigger; a fresh edge does
    na = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ack === 1'b1) na++;
    end
    check("t2_level_no_retrig", 32'(na), 32'd0);
    do_fetch(16'd3, 16'hA5C3, "t2_refetch");

    // 3: address wrap and address sampled at start only
    do_fetch(16'h0105, 16'h5555, "t3_wrap5");
    do_fetch(16'h0103, 16'hA5C3, "t3_wrap3");
    do_fetch(16'd5, 16'h5555, "t3_pre");
    req = 1'b0;
    step();
    addr = 16'd3;
    req  = 1'b1;
    step();
    addr = 16'd5;
    step();
    step();
    check("t3_midchg_ack", 32'(ack), 32'd1);
    check("t3_midchg_ins", 32'(ins), 32'hA5C3);
    req = 1'b0;
    step();

    // 4: load refused while busy, accepted in idle
    addr = 16'd7;
    req  = 1'b1;
    step();
    ld_en   = 1'b1;
    ld_addr = 8'd7;
    ld_data = 16'hDEAD;
    step();
    ld_en = 1'b0;
    check("t4_rej_pulse", 32'(ld_rej), 32'd1);
    step();
    check("t4_rej_clear", 32'(ld_rej), 32'd0);
    check("t4_ack", 32'(ack), 32'd1);
    check("t4_mem7_kept", 32'(ins), 32'h7777);
    req = 1'b0;
    step();
    load(8'd7, 16'hBEEF);
    do_fetch(16'd7, 16'hBEEF, "t4_mem7_new");

    // 5: reset mid-fetch aborts without ack, memory survives
    step();
    addr = 16'd3;
    req  = 1'b1;
    step();
    check("t5_in_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("t5_rst_ins", 32'(ins), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    na = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack === 1'b1) na++;
    end
    check("t5_no_late_ack", 32'(na), 32'd0);
    do_fetch(16'd3, 16'hA5C3, "t5_mem3_kept");
    do_fetch(16'd7, 16'hBEEF, "t5_mem7_kept");

    // 6: same-cycle load and fetch start, matching address
    step();
    ld_en   = 1'b1;
    ld_addr = 8'd9;
    ld_data = 16'h1234;
    addr    = 16'd9;
    req     = 1'b1;
    step();
    ld_en = 1'b0;
    check("t6_no_rej", 32'(ld_rej), 32'd0);
    lat = 0;
    for (int i = 2; i <= 6; i++) begin
      step();
      if (ack === 1'b1 && lat == 0) begin
        lat = i;
        check("t6_ins", 32'(ins), 32'h1234);
      end
    end
    check("t6_lat", 32'(lat), 32'd3);
    req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
